// File: rtl/qk_inst_seq_if.sv
// Control/instruction bundle between the host and qk_inst_seq.
// The hold input exists only when QK_INST_SEQ_HOLD_EN is defined.
interface qk_inst_seq_if;
  logic        start;
  logic        abort;
  logic [18:0] inst;
  logic        busy;
  logic        done;
`ifdef QK_INST_SEQ_HOLD_EN
  logic        hold;
`endif

  modport master (
    output start,
    output abort,
`ifdef QK_INST_SEQ_HOLD_EN
    output hold,
`endif
    input  inst,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
`ifdef QK_INST_SEQ_HOLD_EN
    input  hold,
`endif
    output inst,
    output busy,
    output done
  );
endinterface

// File: rtl/qk_inst_seq.sv
// Q.K attention instruction sequencer: K load, Q execute, OFIFO/SFP accumulate, normalize.
// Optional macro QK_INST_SEQ_HOLD_EN adds a hold input that stalls gap-to-phase transitions.
module qk_inst_seq #(
  parameter logic [7:0] col         = 8'd8,
  parameter logic [7:0] total_cycle = 8'd8,
  parameter logic [9:0] gap         = 10'd10
) (
  input  logic          clk,
  input  logic          reset,
  qk_inst_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_LGAP,
    S_EXEC,
    S_EGAP,
    S_ACC,
    S_AGAP,
    S_NORM,
    S_DONE
  } state_t;

  localparam logic [4:0] LP_COL      = 5'(col);
  localparam logic [4:0] LP_TC       = 5'(total_cycle);
  localparam logic [4:0] LP_LOAD_END = 5'(col + 8'd1);
  localparam logic [4:0] LP_GAP_END  = 5'(gap - 10'd1);
  localparam logic [4:0] LP_TC_END   = 5'(total_cycle - 8'd1);
  localparam logic [4:0] LP_NORM_END = 5'(total_cycle + 8'd1);

  state_t      r_state;
  logic [4:0]  r_c;
  logic [18:0] r_inst;
  logic        r_busy;
  logic        r_done;

  state_t      w_state_nxt;
  logic [4:0]  w_c_nxt;
  logic [18:0] w_inst_nxt;
  logic        w_hold;

`ifdef QK_INST_SEQ_HOLD_EN
  assign w_hold = bus.hold;
`else
  assign w_hold = 1'b0;
`endif

  // Next state and phase counter; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c + 5'd1;
    case (r_state)
      S_IDLE: begin
        w_c_nxt = '0;
        if (bus.start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (r_c == LP_LOAD_END) begin
          w_state_nxt = S_LGAP;
          w_c_nxt     = '0;
        end
      end
      S_LGAP: begin
        if (r_c == LP_GAP_END) begin
          if (w_hold) begin
            w_c_nxt = r_c;
          end else begin
            w_state_nxt = S_EXEC;
            w_c_nxt     = '0;
          end
        end
      end
      S_EXEC: begin
        if (r_c == LP_TC_END) begin
          w_state_nxt = S_EGAP;
          w_c_nxt     = '0;
        end
      end
      S_EGAP: begin
        if (r_c == LP_GAP_END) begin
          if (w_hold) begin
            w_c_nxt = r_c;
          end else begin
            w_state_nxt = S_ACC;
            w_c_nxt     = '0;
          end
        end
      end
      S_ACC: begin
        if (r_c == LP_TC_END) begin
          w_state_nxt = S_AGAP;
          w_c_nxt     = '0;
        end
      end
      S_AGAP: begin
        if (r_c == LP_TC_END) begin
          if (w_hold) begin
            w_c_nxt = r_c;
          end else begin
            w_state_nxt = S_NORM;
            w_c_nxt     = '0;
          end
        end
      end
      S_NORM: begin
        if (r_c == LP_NORM_END) begin
          w_state_nxt = S_DONE;
          w_c_nxt     = '0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_c_nxt     = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_c_nxt     = '0;
      end
    endcase
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_c_nxt     = '0;
    end
  end

  // Instruction is decoded from the upcoming state/counter so the registered
  // output shows each state's c=0 word on the transition edge itself.
  always_comb begin
    w_inst_nxt = '0;
    case (w_state_nxt)
      S_LOAD: begin
        w_inst_nxt[6] = 1'b1;
        if (w_c_nxt >= 5'd1 && w_c_nxt <= LP_COL) begin
          w_inst_nxt[3]     = 1'b1;
          w_inst_nxt[15:12] = w_c_nxt[3:0] - 4'd1;
        end
      end
      S_EXEC: begin
        w_inst_nxt[7]     = 1'b1;
        w_inst_nxt[5]     = 1'b1;
        w_inst_nxt[15:12] = w_c_nxt[3:0];
      end
      S_ACC: begin
        w_inst_nxt[17] = 1'b1;
        w_inst_nxt[16] = 1'b1;
      end
      S_NORM: begin
        if (w_c_nxt <= LP_TC) w_inst_nxt[18] = 1'b1;
        if (w_c_nxt >= 5'd2) begin
          w_inst_nxt[0]    = 1'b1;
          w_inst_nxt[11:8] = w_c_nxt[3:0] - 4'd2;
        end
      end
      default: w_inst_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_inst  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_inst  <= w_inst_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.inst = r_inst;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_qk_inst_seq.sv
// Directed bench for qk_inst_seq with default parameters (col=8, total_cycle=8, gap=10).
module tb_qk_inst_seq;

  logic clk;
  logic reset;
  qk_inst_seq_if bus ();

  qk_inst_seq #(
    .col(8'd8),
    .total_cycle(8'd8),
    .gap(10'd10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [18:0] inst;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        tbl[$];
  logic [20:0] tr[0:79];
  int          n_cmp;
  int          n_err;

  function automatic logic [18:0] mk(input bit dv, input bit ac, input bit of,
                                     input int qa, input int pa, input bit ex,
                                     input bit ld, input bit qr, input bit kr,
                                     input bit pw);
    logic [18:0] r;
    logic [31:0] qv;
    logic [31:0] pv;
    qv = qa;
    pv = pa;
    r = '0;
    r[18] = dv;
    r[17] = ac;
    r[16] = of;
    r[15:12] = qv[3:0];
    r[11:8] = pv[3:0];
    r[7] = ex;
    r[6] = ld;
    r[5] = qr;
    r[3] = kr;
    r[0] = pw;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic capture(input int stray_k);
    for (int k = 0; k < 70; k++) begin
      tr[k] = {bus.inst, bus.busy, bus.done};
      bus.start = (k == stray_k);
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic compare_trace(input string tag);
    int n_ld, n_kr, n_ex, n_dv, n_pw, n_busy, n_done;
    logic [18:0] iv;
    foreach (tbl[i]) begin
      check($sformatf("%s inst k=%0d", tag, tbl[i].k), 32'(tr[tbl[i].k][20:2]), 32'(tbl[i].inst));
      check($sformatf("%s busy k=%0d", tag, tbl[i].k), 32'(tr[tbl[i].k][1]), 32'(tbl[i].busy));
      check($sformatf("%s done k=%0d", tag, tbl[i].k), 32'(tr[tbl[i].k][0]), 32'(tbl[i].done));
    end
    n_ld = 0; n_kr = 0; n_ex = 0; n_dv = 0; n_pw = 0; n_busy = 0; n_done = 0;
    for (int k = 0; k < 70; k++) begin
      iv = tr[k][20:2];
      n_ld   += int'(iv[6]);
      n_kr   += int'(iv[3]);
      n_ex   += int'(iv[7] & iv[5]);
      n_dv   += int'(iv[18]);
      n_pw   += int'(iv[0]);
      n_busy += int'(tr[k][1]);
      n_done += int'(tr[k][0]);
    end
    check({tag, " load cycles"}, 32'(n_ld), 32'd10);
    check({tag, " kmem_rd cycles"}, 32'(n_kr), 32'd8);
    check({tag, " exec cycles"}, 32'(n_ex), 32'd8);
    check({tag, " div cycles"}, 32'(n_dv), 32'd9);
    check({tag, " pmem_wr cycles"}, 32'(n_pw), 32'd8);
    check({tag, " busy cycles"}, 32'(n_busy), 32'd65);
    check({tag, " done pulses"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    int n_done_seen;
    int first_done;
    n_cmp = 0;
    n_err = 0;

    //                     k   inst                                  busy done
    tbl.push_back('{0,  mk(0,0,0,0,0,0,1,0,0,0), 1'b1, 1'b0});
    tbl.push_back('{1,  mk(0,0,0,0,0,0,1,0,1,0), 1'b1, 1'b0});
    tbl.push_back('{2,  mk(0,0,0,1,0,0,1,0,1,0), 1'b1, 1'b0});
    tbl.push_back('{5,  mk(0,0,0,4,0,0,1,0,1,0), 1'b1, 1'b0});
    tbl.push_back('{8,  mk(0,0,0,7,0,0,1,0,1,0), 1'b1, 1'b0});
    tbl.push_back('{9,  mk(0,0,0,0,0,0,1,0,0,0), 1'b1, 1'b0});
    tbl.push_back('{10, 19'h0,                   1'b1, 1'b0});
    tbl.push_back('{19, 19'h0,                   1'b1, 1'b0});
    tbl.push_back('{20, mk(0,0,0,0,0,1,0,1,0,0), 1'b1, 1'b0});
    tbl.push_back('{21, mk(0,0,0,1,0,1,0,1,0,0), 1'b1, 1'b0});
    tbl.push_back('{24, mk(0,0,0,4,0,1,0,1,0,0), 1'b1, 1'b0});
    tbl.push_back('{27, mk(0,0,0,7,0,1,0,1,0,0), 1'b1, 1'b0});
    tbl.push_back('{28, 19'h0,                   1'b1, 1'b0});
    tbl.push_back('{37, 19'h0,                   1'b1, 1'b0});
    tbl.push_back('{38, mk(0,1,1,0,0,0,0,0,0,0), 1'b1, 1'b0});
    tbl.push_back('{45, mk(0,1,1,0,0,0,0,0,0,0), 1'b1, 1'b0});
    tbl.push_back('{46, 19'h0,                   1'b1, 1'b0});
    tbl.push_back('{53, 19'h0,                   1'b1, 1'b0});
    tbl.push_back('{54, mk(1,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0});
    tbl.push_back('{55, mk(1,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0});
    tbl.push_back('{56, mk(1,0,0,0,0,0,0,0,0,1), 1'b1, 1'b0});
    tbl.push_back('{60, mk(1,0,0,0,4,0,0,0,0,1), 1'b1, 1'b0});
    tbl.push_back('{62, mk(1,0,0,0,6,0,0,0,0,1), 1'b1, 1'b0});
    tbl.push_back('{63, mk(0,0,0,0,7,0,0,0,0,1), 1'b1, 1'b0});
    tbl.push_back('{64, 19'h0,                   1'b1, 1'b1});
    tbl.push_back('{65, 19'h0,                   1'b0, 1'b0});
    tbl.push_back('{69, 19'h0,                   1'b0, 1'b0});

    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef QK_INST_SEQ_HOLD_EN
    bus.hold = 1'b0;
`endif
    reset = 1'b1;
    tick();
    tick();
    check("reset inst", 32'(bus.inst), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    tick();
    check("idle busy", 32'(bus.busy), 32'd0);

    // start and abort together in IDLE: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    check("start+abort busy", 32'(bus.busy), 32'd0);
    check("start+abort inst", 32'(bus.inst), 32'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();

    // full run with a stray start pulse during ACC
    launch();
    capture(40);
    compare_trace("run1");

    // abort at the 3rd EXEC cycle
    launch();
    for (int k = 0; k < 22; k++) tick();
    check("pre-abort exec3", 32'(bus.inst), 32'(mk(0,0,0,2,0,1,0,1,0,0)));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort inst", 32'(bus.inst), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    n_done_seen = 0;
    for (int k = 0; k < 70; k++) begin
      n_done_seen += int'(bus.done);
      tick();
    end
    check("abort no done", 32'(n_done_seen), 32'd0);
    launch();
    capture(-1);
    compare_trace("replay");

    // asynchronous reset between edges mid-ACC
    launch();
    for (int k = 0; k < 40; k++) tick();
    check("pre-reset acc", 32'(bus.inst), 32'(mk(0,1,1,0,0,0,0,0,0,0)));
    #3 reset = 1'b1;
    #1;
    check("async reset inst", 32'(bus.inst), 32'd0);
    check("async reset busy", 32'(bus.busy), 32'd0);
    check("async reset done", 32'(bus.done), 32'd0);
    #1 reset = 1'b0;
    tick();
    check("post-reset busy", 32'(bus.busy), 32'd0);

    // back-to-back: start held high through DONE
    bus.start = 1'b1;
    tick();
    for (int k = 0; k < 64; k++) tick();
    check("b2b done", 32'(bus.done), 32'd1);
    tick();
    check("b2b idle busy", 32'(bus.busy), 32'd0);
    check("b2b idle inst", 32'(bus.inst), 32'd0);
    tick();
    check("b2b reload inst", 32'(bus.inst), 32'(mk(0,0,0,0,0,0,1,0,0,0)));
    check("b2b reload busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("b2b abort busy", 32'(bus.busy), 32'd0);
    tick();

`ifdef QK_INST_SEQ_HOLD_EN
    // hold for 5 edges at the end of EGAP delays ACC entry by 5 cycles
    launch();
    for (int k = 0; k < 37; k++) tick();
    check("hold egap last", 32'(bus.inst), 32'd0);
    bus.hold = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("hold waiting inst", 32'(bus.inst), 32'd0);
    check("hold waiting busy", 32'(bus.busy), 32'd1);
    bus.hold = 1'b0;
    tick();
    check("hold acc entry", 32'(bus.inst), 32'(mk(0,1,1,0,0,0,0,0,0,0)));
    first_done = -1;
    for (int k = 44; k < 75; k++) begin
      tick();
      if (bus.done && first_done < 0) first_done = k;
    end
    check("hold done cycle", 32'(first_done), 32'd69);
`else
    first_done = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
